// File: rtl/csr_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : csr_req_arbiter
//  Purpose  : Shares one CSR request/response port among NumReq requesters.
//             Round-robin grant, grant lock until acceptance, at most one
//             outstanding read with response routed back to its owner.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_req_arbiter #(
    parameter int NumReq       = 2,
    parameter int CsrDataWidth = 32,
    parameter int CsrAddrWidth = 32,
    parameter int IdxWidth     = $clog2(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq*CsrDataWidth-1:0]   req_data_i,
    input  logic [NumReq*CsrAddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0]                req_write_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    output logic [NumReq*CsrDataWidth-1:0]   rsp_data_o,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic [CsrDataWidth-1:0]          csr_req_data_o,
    output logic [CsrAddrWidth-1:0]          csr_req_addr_o,
    output logic                             csr_req_write_o,
    output logic                             csr_req_valid_o,
    input  logic                             csr_req_ready_i,
    input  logic [CsrDataWidth-1:0]          csr_rsp_data_i,
    input  logic                             csr_rsp_valid_i,
    output logic                             csr_rsp_ready_o,
    output logic                             busy_o
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StWaitRsp = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] owner_q, owner_d;

    logic [IdxWidth-1:0] arb_idx;
    logic                arb_found;
    logic [IdxWidth-1:0] grant_idx;
    logic                grant_req;
    logic                grant_write;
    logic                route_en;
    logic [IdxWidth-1:0] route_idx;
    logic                route_ready;
    logic                accept;
    logic                rsp_take;

    // Round-robin search: lowest valid index at or above rr_q, else lowest below it
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (IdxWidth'(i) >= rr_q)) begin
                arb_idx   = IdxWidth'(i);
                arb_found = 1'b1;
            end
        end
        if (!arb_found) begin
            for (int i = NumReq - 1; i >= 0; i--) begin
                if (req_valid_i[i] && (IdxWidth'(i) < rr_q)) begin
                    arb_idx   = IdxWidth'(i);
                    arb_found = 1'b1;
                end
            end
        end
    end

    // Resolve the effective grant (locked index wins) and response routing target
    always_comb begin
        grant_idx   = lock_q ? lock_idx_q : arb_idx;
        grant_req   = 1'b0;
        grant_write = 1'b0;
        route_ready = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (IdxWidth'(i) == grant_idx) begin
                grant_req   = lock_q ? req_valid_i[i] : arb_found;
                grant_write = req_write_i[i];
            end
        end
        if (state_q == StWaitRsp) begin
            route_en  = 1'b1;
            route_idx = owner_q;
        end else begin
            route_en  = grant_req;
            route_idx = grant_idx;
        end
        for (int i = 0; i < NumReq; i++) begin
            if (IdxWidth'(i) == route_idx) begin
                route_ready = rsp_ready_i[i];
            end
        end
        accept   = (state_q == StIdle) && grant_req && csr_req_ready_i;
        rsp_take = route_en && csr_rsp_valid_i && route_ready;
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_q       <= '0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
        end
    end

    // Next-state: acceptance advances the pointer; an unaccepted grant locks
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    lock_d = 1'b0;
                    rr_d   = (grant_idx == IdxWidth'(NumReq - 1)) ? '0
                                                                  : grant_idx + IdxWidth'(1);
                    if (!grant_write) begin
                        owner_d = grant_idx;
                        if (!rsp_take) begin
                            state_d = StWaitRsp;
                        end
                    end
                end else if (grant_req) begin
                    lock_d     = 1'b1;
                    lock_idx_d = grant_idx;
                end
            end
            StWaitRsp: begin
                if (rsp_take) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: forward the grant, route the response; everything low in reset
    always_comb begin
        req_ready_o     = '0;
        rsp_data_o      = '0;
        rsp_valid_o     = '0;
        csr_req_data_o  = '0;
        csr_req_addr_o  = '0;
        csr_req_write_o = 1'b0;
        csr_req_valid_o = 1'b0;
        csr_rsp_ready_o = 1'b0;
        busy_o          = 1'b0;
        if (rst_ni) begin
            busy_o = (state_q == StWaitRsp);
            for (int i = 0; i < NumReq; i++) begin
                if ((state_q == StIdle) && grant_req && (IdxWidth'(i) == grant_idx)) begin
                    csr_req_data_o  = req_data_i[i*CsrDataWidth +: CsrDataWidth];
                    csr_req_addr_o  = req_addr_i[i*CsrAddrWidth +: CsrAddrWidth];
                    csr_req_write_o = req_write_i[i];
                    csr_req_valid_o = 1'b1;
                    req_ready_o[i]  = csr_req_ready_i;
                end
                if (route_en && (IdxWidth'(i) == route_idx)) begin
                    rsp_valid_o[i]                               = csr_rsp_valid_i;
                    rsp_data_o[i*CsrDataWidth +: CsrDataWidth]   = csr_rsp_data_i;
                    csr_rsp_ready_o                              = rsp_ready_i[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_req_arbiter
//  Purpose  : Directed self-checking bench for csr_req_arbiter (2 requesters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_req_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] req_data_i;
    logic [63:0] req_addr_i;
    logic [1:0]  req_write_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] rsp_data_o;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] csr_req_data_o;
    logic [31:0] csr_req_addr_o;
    logic        csr_req_write_o;
    logic        csr_req_valid_o;
    logic        csr_req_ready_i;
    logic [31:0] csr_rsp_data_i;
    logic        csr_rsp_valid_i;
    logic        csr_rsp_ready_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    csr_req_arbiter #(
        .NumReq      (2),
        .CsrDataWidth(32),
        .CsrAddrWidth(32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_data_i     (req_data_i),
        .req_addr_i     (req_addr_i),
        .req_write_i    (req_write_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .csr_req_data_o (csr_req_data_o),
        .csr_req_addr_o (csr_req_addr_o),
        .csr_req_write_o(csr_req_write_o),
        .csr_req_valid_o(csr_req_valid_o),
        .csr_req_ready_i(csr_req_ready_i),
        .csr_rsp_data_i (csr_rsp_data_i),
        .csr_rsp_valid_i(csr_rsp_valid_i),
        .csr_rsp_ready_o(csr_rsp_ready_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        req_data_i      = '0;
        req_addr_i      = '0;
        req_write_i     = '0;
        req_valid_i     = '0;
        rsp_ready_i     = '0;
        csr_req_ready_i = 1'b0;
        csr_rsp_data_i  = '0;
        csr_rsp_valid_i = 1'b0;
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni          = 1'b0;
        req_valid_i     = 2'b11;
        req_write_i     = 2'b11;
        csr_req_ready_i = 1'b1;
        csr_rsp_valid_i = 1'b1;
        rsp_ready_i     = 2'b11;
        @(negedge clk_i);
        checks++; if (csr_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_csr_req_valid got %b exp 0", csr_req_valid_o); end
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready_o); end
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        step();
        idle_inputs();
        rst_ni = 1'b1;
        step();
    endtask

    // req1 read, accepted and answered in the same cycle (rr_q stays 0)
    task automatic test_pass_through();
        idle_inputs();
        req_valid_i      = 2'b10;
        req_write_i      = 2'b00;
        req_addr_i       = {32'h0000_0003, 32'h0};
        csr_req_ready_i  = 1'b1;
        csr_rsp_valid_i  = 1'b1;
        csr_rsp_data_i   = 32'h0000_0105;
        rsp_ready_i      = 2'b10;
        @(negedge clk_i);
        checks++; if (csr_req_addr_o !== 32'h3) begin errors++; $display("FAIL pt_addr got %h exp 00000003", csr_req_addr_o); end
        checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL pt_req_ready got %b exp 10", req_ready_o); end
        checks++; if (rsp_valid_o !== 2'b10) begin errors++; $display("FAIL pt_rsp_valid got %b exp 10", rsp_valid_o); end
        checks++; if (rsp_data_o !== 64'h0000_0105_0000_0000) begin errors++; $display("FAIL pt_rsp_data got %h exp 0000010500000000", rsp_data_o); end
        checks++; if (csr_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL pt_csr_rsp_ready got %b exp 1", csr_rsp_ready_o); end
        step();
        // idle with a stray response: must be ignored
        idle_inputs();
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = 32'hDEAD_BEEF;
        rsp_ready_i     = 2'b11;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pt_busy_after got %b exp 0", busy_o); end
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL stray_rsp_valid got %b exp 00", rsp_valid_o); end
        checks++; if (csr_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL stray_csr_rsp_ready got %b exp 0", csr_rsp_ready_o); end
        step();
    endtask

    // both requesters stream writes: grants alternate 0,1,0,1 starting from rr_q=0
    task automatic test_fairness();
        logic [31:0] exp_addr [4];
        logic [1:0]  exp_rdy  [4];
        exp_addr = '{32'h100, 32'h104, 32'h100, 32'h104};
        exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
        idle_inputs();
        req_valid_i     = 2'b11;
        req_write_i     = 2'b11;
        req_addr_i      = {32'h104, 32'h100};
        req_data_i      = {32'hBBBB_0001, 32'hAAAA_0000};
        csr_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checks++; if (csr_req_addr_o !== exp_addr[k]) begin errors++; $display("FAIL fair_addr[%0d] got %h exp %h", k, csr_req_addr_o, exp_addr[k]); end
            checks++; if (req_ready_o !== exp_rdy[k]) begin errors++; $display("FAIL fair_ready[%0d] got %b exp %b", k, req_ready_o, exp_rdy[k]); end
            step();
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fair_busy got %b exp 0", busy_o); end
    endtask

    // rr_q moved to 1, then req0 granted by wrap and held while req1 also requests
    task automatic test_lock();
        idle_inputs();
        req_valid_i     = 2'b01;
        req_write_i     = 2'b11;
        req_addr_i      = {32'h204, 32'h200};
        csr_req_ready_i = 1'b1;
        step();                       // req0 accepted, rr_q -> 1
        csr_req_ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (csr_req_addr_o !== 32'h200 || csr_req_valid_o !== 1'b1) begin errors++; $display("FAIL lock_c0 got addr %h valid %b exp 200/1", csr_req_addr_o, csr_req_valid_o); end
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL lock_c0_ready got %b exp 00", req_ready_o); end
        step();
        req_valid_i = 2'b11;
        @(negedge clk_i);
        checks++; if (csr_req_addr_o !== 32'h200) begin errors++; $display("FAIL lock_c1_addr got %h exp 00000200", csr_req_addr_o); end
        step();
        csr_req_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (csr_req_addr_o !== 32'h200 || req_ready_o !== 2'b01) begin errors++; $display("FAIL lock_accept got addr %h ready %b exp 200/01", csr_req_addr_o, req_ready_o); end
        step();
        @(negedge clk_i);
        checks++; if (csr_req_addr_o !== 32'h204 || req_ready_o !== 2'b10) begin errors++; $display("FAIL lock_next got addr %h ready %b exp 204/10", csr_req_addr_o, req_ready_o); end
        step();                       // rr_q -> 0
    endtask

    // req0 read held 3 cycles by rsp_ready_i[0]=0; req1 write waits behind it
    task automatic test_held_response();
        idle_inputs();
        req_valid_i     = 2'b11;
        req_write_i     = 2'b10;
        req_addr_i      = {32'h20, 32'h10};
        csr_req_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (req_ready_o !== 2'b01 || csr_req_write_o !== 1'b0) begin errors++; $display("FAIL held_grant got ready %b write %b exp 01/0", req_ready_o, csr_req_write_o); end
        step();
        req_valid_i     = 2'b10;
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = 32'h0000_ABCD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL held_busy[%0d] got %b exp 1", k, busy_o); end
            checks++; if (req_ready_o !== 2'b00 || csr_req_valid_o !== 1'b0) begin errors++; $display("FAIL held_block[%0d] got ready %b valid %b exp 00/0", k, req_ready_o, csr_req_valid_o); end
            checks++; if (rsp_valid_o !== 2'b01 || csr_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL held_rsp[%0d] got valid %b ready %b exp 01/0", k, rsp_valid_o, csr_rsp_ready_o); end
            step();
        end
        rsp_ready_i = 2'b01;
        @(negedge clk_i);
        checks++; if (rsp_data_o !== 64'h0000_0000_0000_ABCD || csr_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL held_complete got data %h ready %b exp 000000000000abcd/1", rsp_data_o, csr_rsp_ready_o); end
        step();
        csr_rsp_valid_i = 1'b0;
        rsp_ready_i     = 2'b00;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || req_ready_o !== 2'b10 || csr_req_addr_o !== 32'h20) begin errors++; $display("FAIL held_write_after got busy %b ready %b addr %h exp 0/10/20", busy_o, req_ready_o, csr_req_addr_o); end
        step();                       // rr_q -> 0
    endtask

    // reset while req1 read outstanding, then a late response must be ignored
    task automatic test_reset_mid_read();
        idle_inputs();
        req_valid_i     = 2'b10;
        req_write_i     = 2'b00;
        req_addr_i      = {32'h30, 32'h0};
        csr_req_ready_i = 1'b1;
        step();
        idle_inputs();
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmr_busy_before got %b exp 1", busy_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmr_busy_in_reset got %b exp 0", busy_o); end
        step();
        rst_ni = 1'b1;
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = 32'h1234_5678;
        rsp_ready_i     = 2'b11;
        @(negedge clk_i);
        checks++; if (rsp_valid_o !== 2'b00 || csr_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL rmr_late_rsp got valid %b ready %b exp 00/0", rsp_valid_o, csr_rsp_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmr_busy_after got %b exp 0", busy_o); end
        step();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_pass_through();
        test_fairness();
        test_lock();
        test_held_response();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
